// File: rtl/gray_pos_tracker_pkg.sv
// Shared definitions for the 3-bit gray position path: tracker states, the
// gray code sequence produced by the upstream counter, and step classification.
package gray_pos_tracker_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_e;

  // Upstream counter sequence, in counting order.
  localparam logic [2:0] s0 = 3'b000;
  localparam logic [2:0] s1 = 3'b001;
  localparam logic [2:0] s2 = 3'b011;
  localparam logic [2:0] s3 = 3'b010;
  localparam logic [2:0] s4 = 3'b110;
  localparam logic [2:0] s5 = 3'b111;
  localparam logic [2:0] s6 = 3'b101;
  localparam logic [2:0] s7 = 3'b100;

  localparam int POS_W_MIN = 4;
  localparam int POS_W_MAX = 16;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DN   = 2'd2,
    STEP_SKIP = 2'd3
  } step_e;

  // Mod-8 distance between consecutive samples; anything but 0/+1/-1 means
  // the sampler missed at least one code.
  function automatic step_e classify_delta(input logic [2:0] delta);
    case (delta)
      3'd0:    return STEP_NONE;
      3'd1:    return STEP_UP;
      3'd7:    return STEP_DN;
      default: return STEP_SKIP;
    endcase
  endfunction

endpackage

// File: rtl/gray2bin.sv
// 3-bit combinational gray-to-binary decoder, shared by every consumer of the
// upstream gray counter.
module gray2bin (
  input  logic [2:0] gray,
  output logic [2:0] bin
);

  assign bin[2] = gray[2];
  assign bin[1] = gray[2] ^ gray[1];
  assign bin[0] = gray[2] ^ gray[1] ^ gray[0];

endmodule

// File: rtl/gray_pos_tracker.sv
// Two-stage tracker turning a negedge-updated 3-bit gray counter into a signed
// step count, with up/down pulses and a latched fault on skipped codes.
module gray_pos_tracker
  import gray_pos_tracker_pkg::*;
#(
  parameter int POS_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       gray_in,
  input  logic             clear,
  input  logic             err_clr,
  output logic [2:0]       bin_out,
  output logic [POS_W-1:0] position,
  output logic             step_up,
  output logic             step_dn,
  output logic             skip_err,
  output logic             valid
);

  localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

  state_e           state, state_nxt;
  logic [2:0]       g_q;
  logic             g_vld;
  logic [2:0]       b_cur;
  logic [2:0]       b_prev, b_prev_nxt;
  logic [2:0]       delta;
  step_e            step;
  logic [2:0]       bin_nxt;
  logic [POS_W-1:0] pos_nxt;
  logic             up_nxt, dn_nxt;

  gray2bin u_gray2bin (
    .gray (g_q),
    .bin  (b_cur)
  );

  assign delta = b_cur - b_prev;
  assign step  = classify_delta(delta);

  // Stage 1. g_vld marks that g_q holds a real sample rather than the reset
  // value, so INIT never baselines on a stale code.
  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      g_q   <= 3'b000;
      g_vld <= 1'b0;
    end else begin
      g_q   <= gray_in;
      g_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= INIT;
    else        state <= state_nxt;
  end

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt  = state;
    b_prev_nxt = b_prev;
    bin_nxt    = bin_out;
    pos_nxt    = position;
    up_nxt     = 1'b0;
    dn_nxt     = 1'b0;
    case (state)
      INIT: begin
        if (g_vld) begin
          b_prev_nxt = b_cur;
          bin_nxt    = b_cur;
          state_nxt  = TRACK;
        end
      end
      TRACK: begin
        b_prev_nxt = b_cur;
        bin_nxt    = b_cur;
        case (step)
          STEP_UP: begin
            pos_nxt = position + POS_ONE;
            up_nxt  = 1'b1;
          end
          STEP_DN: begin
            pos_nxt = position - POS_ONE;
            dn_nxt  = 1'b1;
          end
          STEP_SKIP: state_nxt = FAULT;
          default:   ;
        endcase
      end
      FAULT: begin
        if (err_clr) state_nxt = INIT;
      end
      default: state_nxt = INIT;
    endcase
    // Clear overrides any step in the same cycle; the baseline still advances.
    if (clear) begin
      pos_nxt = '0;
      up_nxt  = 1'b0;
      dn_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      b_prev   <= 3'b000;
      bin_out  <= 3'b000;
      position <= '0;
      step_up  <= 1'b0;
      step_dn  <= 1'b0;
    end else begin
      b_prev   <= b_prev_nxt;
      bin_out  <= bin_nxt;
      position <= pos_nxt;
      step_up  <= up_nxt;
      step_dn  <= dn_nxt;
    end
  end

  always_comb begin
    valid    = (state == TRACK);
    skip_err = (state == FAULT);
  end

endmodule

// File: tb/tb_gray_pos_tracker.sv
// Directed bench for gray_pos_tracker (POS_W=8): gray codes are driven on the
// falling edge like the upstream counter, outputs are sampled there too.
module tb_gray_pos_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] gray_in;
  logic       clear;
  logic       err_clr;
  logic [2:0] bin_out;
  logic [7:0] position;
  logic       step_up;
  logic       step_dn;
  logic       skip_err;
  logic       valid;

  int checks   = 0;
  int failures = 0;
  int up_cnt   = 0;
  int dn_cnt   = 0;
  logic [2:0] cur_b = 3'd0;

  gray_pos_tracker #(.POS_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .gray_in  (gray_in),
    .clear    (clear),
    .err_clr  (err_clr),
    .bin_out  (bin_out),
    .position (position),
    .step_up  (step_up),
    .step_dn  (step_dn),
    .skip_err (skip_err),
    .valid    (valid)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  function automatic logic [2:0] to_gray(input logic [2:0] b);
    return b ^ (b >> 1);
  endfunction

  // One falling edge: tally the pulses of the last rising edge, then drive g.
  task automatic tick(input logic [2:0] g);
    @(negedge clk);
    if (step_up) up_cnt++;
    if (step_dn) dn_cnt++;
    checks++;
    if (step_up && step_dn) begin
      failures++;
      $display("FAIL pulse_exclusive got up=%0b dn=%0b required not both 1", step_up, step_dn);
    end
    gray_in = g;
  endtask

  task automatic flush();
    tick(gray_in);
    tick(gray_in);
  endtask

  task automatic step_up_n(input int n);
    for (int i = 0; i < n; i++) begin
      cur_b = cur_b + 3'd1;
      tick(to_gray(cur_b));
    end
  endtask

  task automatic step_dn_n(input int n);
    for (int i = 0; i < n; i++) begin
      cur_b = cur_b - 3'd1;
      tick(to_gray(cur_b));
    end
  endtask

  task automatic clear_pulse();
    tick(gray_in);
    clear = 1'b1;
    tick(gray_in);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; gray_in = 3'b000; clear = 1'b0; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bin_out, position, step_up, step_dn, skip_err, valid} !== 15'd0) begin
      failures++;
      $display("FAIL reset_outputs got bin=%0d pos=%0h up=%0b dn=%0b err=%0b valid=%0b required all 0",
               bin_out, position, step_up, step_dn, skip_err, valid);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid_edge1 got %0b required 0", valid);
    end
    @(negedge clk);
    checks++;
    if (valid !== 1'b1 || position !== 8'h00 || bin_out !== 3'd0) begin
      failures++;
      $display("FAIL reset_valid_edge2 got valid=%0b pos=%0h bin=%0d required 1/00/0", valid, position, bin_out);
    end
    up_cnt = 0; dn_cnt = 0;
    tick(3'b000);
    tick(3'b000);
    checks++;
    if (up_cnt != 0 || dn_cnt != 0 || position !== 8'h00) begin
      failures++;
      $display("FAIL reset_idle got up=%0d dn=%0d pos=%0h required 0/0/00", up_cnt, dn_cnt, position);
    end
  endtask

  task automatic test_count_up();
    up_cnt = 0; dn_cnt = 0; cur_b = 3'd0;
    step_up_n(8);
    flush();
    checks++;
    if (up_cnt != 8 || dn_cnt != 0) begin
      failures++;
      $display("FAIL up_pulses got up=%0d dn=%0d required 8/0", up_cnt, dn_cnt);
    end
    checks++;
    if (position !== 8'h08 || bin_out !== 3'd0) begin
      failures++;
      $display("FAIL up_position got pos=%0h bin=%0d required 08/0", position, bin_out);
    end
  endtask

  task automatic test_count_down();
    clear_pulse();
    checks++;
    if (position !== 8'h00) begin
      failures++;
      $display("FAIL clear_to_zero got %0h required 00", position);
    end
    up_cnt = 0; dn_cnt = 0;
    step_dn_n(2);
    flush();
    checks++;
    if (dn_cnt != 2 || up_cnt != 0) begin
      failures++;
      $display("FAIL down_pulses got up=%0d dn=%0d required 0/2", up_cnt, dn_cnt);
    end
    checks++;
    if (position !== 8'hFE || bin_out !== 3'd6) begin
      failures++;
      $display("FAIL down_position got pos=%0h bin=%0d required fe/6", position, bin_out);
    end
  endtask

  task automatic test_clear_collision();
    clear_pulse();
    step_up_n(5);
    flush();
    checks++;
    if (position !== 8'h05) begin
      failures++;
      $display("FAIL collide_setup got %0h required 05", position);
    end
    up_cnt = 0;
    cur_b = 3'd4;
    tick(to_gray(cur_b));
    tick(gray_in);
    clear = 1'b1;
    tick(gray_in);
    clear = 1'b0;
    checks++;
    if (position !== 8'h00 || up_cnt != 0) begin
      failures++;
      $display("FAIL collide_clear got pos=%0h up=%0d required 00/0", position, up_cnt);
    end
    step_up_n(1);
    flush();
    checks++;
    if (position !== 8'h01 || up_cnt != 1 || skip_err !== 1'b0) begin
      failures++;
      $display("FAIL collide_baseline got pos=%0h up=%0d err=%0b required 01/1/0", position, up_cnt, skip_err);
    end
  endtask

  task automatic test_wrap();
    clear_pulse();
    up_cnt = 0;
    step_up_n(127);
    flush();
    checks++;
    if (position !== 8'h7F) begin
      failures++;
      $display("FAIL wrap_pre got %0h required 7f", position);
    end
    step_up_n(1);
    flush();
    checks++;
    if (position !== 8'h80 || up_cnt != 128) begin
      failures++;
      $display("FAIL wrap_post got pos=%0h up=%0d required 80/128", position, up_cnt);
    end
  endtask

  task automatic test_fault();
    step_up_n(4);
    flush();
    checks++;
    if (position !== 8'h84 || bin_out !== 3'd1 || valid !== 1'b1) begin
      failures++;
      $display("FAIL fault_setup got pos=%0h bin=%0d valid=%0b required 84/1/1", position, bin_out, valid);
    end
    up_cnt = 0; dn_cnt = 0;
    tick(3'b110);
    flush();
    checks++;
    if (skip_err !== 1'b1 || valid !== 1'b0 || position !== 8'h84 || up_cnt != 0 || dn_cnt != 0) begin
      failures++;
      $display("FAIL fault_enter got err=%0b valid=%0b pos=%0h up=%0d dn=%0d required 1/0/84/0/0",
               skip_err, valid, position, up_cnt, dn_cnt);
    end
    tick(3'b111);
    tick(3'b101);
    tick(3'b110);
    flush();
    checks++;
    if (skip_err !== 1'b1 || position !== 8'h84 || up_cnt != 0 || dn_cnt != 0) begin
      failures++;
      $display("FAIL fault_hold got err=%0b pos=%0h up=%0d dn=%0d required 1/84/0/0", skip_err, position, up_cnt, dn_cnt);
    end
    tick(gray_in);
    err_clr = 1'b1;
    tick(gray_in);
    err_clr = 1'b0;
    checks++;
    if (valid !== 1'b0 || skip_err !== 1'b0) begin
      failures++;
      $display("FAIL fault_to_init got valid=%0b err=%0b required 0/0", valid, skip_err);
    end
    tick(gray_in);
    checks++;
    if (valid !== 1'b1 || bin_out !== 3'd4 || position !== 8'h84 || up_cnt != 0 || dn_cnt != 0) begin
      failures++;
      $display("FAIL fault_rebase got valid=%0b bin=%0d pos=%0h up=%0d dn=%0d required 1/4/84/0/0",
               valid, bin_out, position, up_cnt, dn_cnt);
    end
    cur_b = 3'd4;
    step_up_n(1);
    flush();
    checks++;
    if (position !== 8'h85 || up_cnt != 1) begin
      failures++;
      $display("FAIL fault_resume got pos=%0h up=%0d required 85/1", position, up_cnt);
    end
  endtask

  task automatic test_err_clr_in_track();
    tick(gray_in);
    err_clr = 1'b1;
    tick(gray_in);
    tick(gray_in);
    err_clr = 1'b0;
    tick(gray_in);
    checks++;
    if (valid !== 1'b1 || skip_err !== 1'b0 || position !== 8'h85) begin
      failures++;
      $display("FAIL errclr_ignored got valid=%0b err=%0b pos=%0h required 1/0/85", valid, skip_err, position);
    end
  endtask

  task automatic test_reset_mid();
    clear_pulse();
    step_up_n(3);
    flush();
    checks++;
    if (position !== 8'h03) begin
      failures++;
      $display("FAIL rstmid_setup got %0h required 03", position);
    end
    cur_b = cur_b + 3'd1;
    tick(to_gray(cur_b));
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (position !== 8'h00 || valid !== 1'b0 || step_up !== 1'b0 || bin_out !== 3'd0) begin
      failures++;
      $display("FAIL rstmid_async got pos=%0h valid=%0b up=%0b bin=%0d required 00/0/0/0",
               position, valid, step_up, bin_out);
    end
    up_cnt = 0; dn_cnt = 0;
    cur_b = cur_b + 3'd1;
    tick(to_gray(cur_b));
    reset = 1'b1;
    cur_b = cur_b + 3'd1;
    tick(to_gray(cur_b));
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_edge1 got valid=%0b required 0", valid);
    end
    tick(gray_in);
    checks++;
    if (valid !== 1'b1 || position !== 8'h00 || up_cnt != 0 || dn_cnt != 0) begin
      failures++;
      $display("FAIL rstmid_edge2 got valid=%0b pos=%0h up=%0d dn=%0d required 1/00/0/0",
               valid, position, up_cnt, dn_cnt);
    end
    tick(gray_in);
    checks++;
    if (position !== 8'h01 || up_cnt != 1) begin
      failures++;
      $display("FAIL rstmid_resume got pos=%0h up=%0d required 01/1", position, up_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_clear_collision();
    test_wrap();
    test_fault();
    test_err_clr_in_track();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
